// File: rtl/rpc_io_pkg.sv
// Shared types for the RPC pad turnaround buffer.
// Bus-state encoding, direction request codes and a width helper.
package rpc_io_pkg;

    typedef enum logic [2:0] {
        S_HIZ   = 3'd0,
        S_PRE   = 3'd1,
        S_DRIVE = 3'd2,
        S_TURN  = 3'd3,
        S_RX    = 3'd4
    } rpc_bus_state_e;

    typedef enum logic [1:0] {
        DIR_HIZ = 2'b00,
        DIR_RX  = 2'b01,
        DIR_TX  = 2'b10
    } rpc_dir_req_e;

    localparam int RPC_STATE_W = 3;

    function automatic int rpc_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/iobuf_rpc_pad_bit.sv
// Single bidirectional pad: IOBUF with DRIVE 12, SLEW FAST,
// IBUF_LOW_PWR FALSE and T = ~oe.
module iobuf_rpc_pad_bit (
    input  logic o_i,
    input  logic oe_i,
    output logic i_o,
    inout  wire  pad_io
);

    logic t;

    assign t      = ~oe_i;
    assign pad_io = t ? 1'bz : o_i;
    assign i_o    = pad_io;

endmodule

// File: rtl/iobuf_rpc_turnaround.sv
// RPC pad buffer with a direction FSM enforcing preamble and
// turnaround guard cycles; all pad outputs, enables and inputs registered.
module iobuf_rpc_turnaround #(
    parameter int DB_WIDTH    = 16,
    parameter int PRE_CYCLES  = 1,
    parameter int TURN_CYCLES = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [1:0]          dir_req_i,
    input  logic                dir_valid_i,
    output logic                dir_ready_o,
    input  logic [DB_WIDTH-1:0] tx_data_i,
    input  logic                tx_dqs_i,
    input  logic                tx_valid_i,
    output logic                tx_ready_o,
    output logic [DB_WIDTH-1:0] rx_data_o,
    output logic                rx_dqs_o,
    output logic                rx_dqsn_o,
    output logic                rx_valid_o,
    output logic [2:0]          bus_state_o,
    inout  wire                 dqs_io,
    inout  wire                 dqsn_io,
    inout  wire  [DB_WIDTH-1:0] db_io
);

    import rpc_io_pkg::*;

    localparam int CNT_W = $clog2(rpc_max(PRE_CYCLES, TURN_CYCLES) + 1);
    localparam logic [CNT_W-1:0] PRE_TERM  = CNT_W'(PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_TERM = CNT_W'(TURN_CYCLES - 1);
    localparam rpc_bus_state_e TX_ENTRY =
        (PRE_CYCLES == 0) ? S_DRIVE : S_PRE;

    rpc_bus_state_e      state_q, state_d;
    rpc_dir_req_e        dest_q, dest_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                oe_q, oe_d;
    logic [DB_WIDTH-1:0] db_q, db_d;
    logic                dqs_q, dqs_d;
    logic                drain_q, drain_d;
    logic                dir_ready_q, dir_ready_d;
    logic                tx_ready_q, tx_ready_d;
    logic [DB_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                rx_dqs_q, rx_dqs_d;
    logic                rx_dqsn_q, rx_dqsn_d;
    logic                rx_valid_q, rx_valid_d;

    logic                dir_acc;
    logic                tx_acc;
    logic                req_tx;
    logic                req_rx;
    logic [DB_WIDTH+1:0] pad_o;
    logic [DB_WIDTH+1:0] pad_i;

    assign dir_acc = dir_valid_i & dir_ready_q;
    assign tx_acc  = tx_valid_i & tx_ready_q;
    assign req_tx  = (dir_req_i == DIR_TX);
    assign req_rx  = (dir_req_i == DIR_RX);

    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        cnt_d   = cnt_q;
        oe_d    = oe_q;
        db_d    = db_q;
        dqs_d   = dqs_q;
        drain_d = drain_q;
        unique case (state_q)
            S_HIZ: begin
                oe_d = 1'b0;
                if (dir_acc && req_tx) begin
                    state_d = TX_ENTRY;
                    cnt_d   = '0;
                    oe_d    = 1'b1;
                    db_d    = '0;
                    dqs_d   = 1'b0;
                end else if (dir_acc && req_rx) begin
                    state_d = S_RX;
                    cnt_d   = '0;
                end
            end
            S_PRE: begin
                oe_d  = 1'b1;
                db_d  = '0;
                dqs_d = 1'b0;
                if (cnt_q == PRE_TERM) begin
                    state_d = S_DRIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRIVE: begin
                if (tx_acc) begin
                    db_d  = tx_data_i;
                    dqs_d = tx_dqs_i;
                end else begin
                    dqs_d = 1'b0;
                end
                // A word accepted with the direction change drains for one cycle first.
                if (drain_q) begin
                    state_d = S_TURN;
                    cnt_d   = '0;
                    oe_d    = 1'b0;
                    drain_d = 1'b0;
                end else if (dir_acc && !req_tx) begin
                    dest_d = req_rx ? DIR_RX : DIR_HIZ;
                    if (tx_acc) begin
                        drain_d = 1'b1;
                    end else begin
                        state_d = S_TURN;
                        cnt_d   = '0;
                        oe_d    = 1'b0;
                    end
                end
            end
            S_TURN: begin
                oe_d = 1'b0;
                if (cnt_q == TURN_TERM) begin
                    cnt_d = '0;
                    if (dest_q == DIR_RX) begin
                        state_d = S_RX;
                    end else if (dest_q == DIR_TX) begin
                        state_d = TX_ENTRY;
                        oe_d    = 1'b1;
                        db_d    = '0;
                        dqs_d   = 1'b0;
                    end else begin
                        state_d = S_HIZ;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RX: begin
                oe_d = 1'b0;
                if (dir_acc && req_tx) begin
                    state_d = S_TURN;
                    dest_d  = DIR_TX;
                    cnt_d   = '0;
                end else if (dir_acc && !req_rx) begin
                    state_d = S_HIZ;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_HIZ;
                cnt_d   = '0;
                oe_d    = 1'b0;
                drain_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        dir_ready_d = ((state_d == S_HIZ) || (state_d == S_DRIVE) ||
                       (state_d == S_RX)) && !drain_d;
        tx_ready_d  = (state_d == S_DRIVE) && !drain_d;
        rx_data_d   = pad_i[DB_WIDTH-1:0];
        rx_dqs_d    = pad_i[DB_WIDTH];
        rx_dqsn_d   = pad_i[DB_WIDTH+1];
        rx_valid_d  = (state_q == S_RX);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_HIZ;
            dest_q      <= DIR_HIZ;
            cnt_q       <= '0;
            oe_q        <= 1'b0;
            db_q        <= '0;
            dqs_q       <= 1'b0;
            drain_q     <= 1'b0;
            dir_ready_q <= 1'b1;
            tx_ready_q  <= 1'b0;
            rx_data_q   <= '0;
            rx_dqs_q    <= 1'b0;
            rx_dqsn_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            cnt_q       <= cnt_d;
            oe_q        <= oe_d;
            db_q        <= db_d;
            dqs_q       <= dqs_d;
            drain_q     <= drain_d;
            dir_ready_q <= dir_ready_d;
            tx_ready_q  <= tx_ready_d;
            rx_data_q   <= rx_data_d;
            rx_dqs_q    <= rx_dqs_d;
            rx_dqsn_q   <= rx_dqsn_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

    assign pad_o = {~dqs_q, dqs_q, db_q};

    for (genvar g = 0; g < DB_WIDTH + 2; g++) begin : g_pad
        if (g < DB_WIDTH) begin : g_db
            iobuf_rpc_pad_bit u_pad (
                .o_i   (pad_o[g]),
                .oe_i  (oe_q),
                .i_o   (pad_i[g]),
                .pad_io(db_io[g])
            );
        end else if (g == DB_WIDTH) begin : g_dqs
            iobuf_rpc_pad_bit u_pad (
                .o_i   (pad_o[g]),
                .oe_i  (oe_q),
                .i_o   (pad_i[g]),
                .pad_io(dqs_io)
            );
        end else begin : g_dqsn
            iobuf_rpc_pad_bit u_pad (
                .o_i   (pad_o[g]),
                .oe_i  (oe_q),
                .i_o   (pad_i[g]),
                .pad_io(dqsn_io)
            );
        end
    end

    assign dir_ready_o = dir_ready_q;
    assign tx_ready_o  = tx_ready_q;
    assign rx_data_o   = rx_data_q;
    assign rx_dqs_o    = rx_dqs_q;
    assign rx_dqsn_o   = rx_dqsn_q;
    assign rx_valid_o  = rx_valid_q;
    assign bus_state_o = state_q;

endmodule
